// File: rtl/mt9v034_pkg.sv
// -----------------------------------------------------------------------------
// mt9v034_pkg
// Shared definitions for the MT9V034 embedded-sync decoder:
//   - 10-bit embedded sync code values
//   - decoder FSM state encoding
//   - small saturating-counter helpers
// -----------------------------------------------------------------------------
package mt9v034_pkg;

  localparam logic [9:0] SYNC_FS0  = 10'd1023;
  localparam logic [9:0] SYNC_FS1  = 10'd0;
  localparam logic [9:0] SYNC_LS   = 10'd1;
  localparam logic [9:0] SYNC_LE   = 10'd2;
  localparam logic [9:0] SYNC_FE   = 10'd3;
  localparam logic [9:0] SYNC_IDLE = 10'd4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC1 = 3'd1,
    SYNC2 = 3'd2,
    FRAME = 3'd3,
    LINE  = 3'd4
  } state_e;

  // Pixel counter increment that sticks at all-ones.
  function automatic logic [11:0] pix_sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  // Line counter increment that sticks at all-ones.
  function automatic logic [9:0] line_sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/mt9v034_sync_fifo.sv
// -----------------------------------------------------------------------------
// mt9v034_sync_fifo
// Single-clock FIFO. Head entry is visible on pop_data whenever empty=0.
// A push while full is accepted only if a pop happens in the same cycle.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   push, push_data write request and data
//   pop             read request (ignored when empty)
//   pop_data        current head entry
//   full, empty     occupancy flags
// -----------------------------------------------------------------------------
module mt9v034_sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             wr_en_s;
  logic             rd_en_s;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en_s  = pop && !empty;
  assign wr_en_s  = push && (!full || rd_en_s);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care while the entry is unoccupied.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/mt9v034_sync_decoder.sv
// -----------------------------------------------------------------------------
// mt9v034_sync_decoder
// Decodes embedded syncs in the deserialized MT9V034 word stream and emits
// active pixels as AXI4-Stream video (tuser = start of frame, tlast = end of
// line). Checks line/frame geometry and flags output FIFO overflow.
// Ports:
//   clk, rst             word clock, synchronous active-high reset
//   in_data, in_valid    10-bit sensor word, valid strobe (cannot stall)
//   m_axis_*             AXI4-Stream master, tdata = {6'b0, pixel}
//   frame_active         high between frame-start sync and frame-end code
//   frame_count          completed frames (wrapping)
//   err_line_len         sticky: line length != H_ACTIVE
//   err_frame_lines      sticky: frame line count != V_ACTIVE, or frame aborted
//   err_overflow         sticky: pixel dropped on full FIFO
//   clear_err            pulse clearing the sticky errors
// -----------------------------------------------------------------------------
module mt9v034_sync_decoder
  import mt9v034_pkg::*;
#(
  parameter int H_ACTIVE   = 64,
  parameter int V_ACTIVE   = 48,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  in_data,
  input  logic        in_valid,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        frame_active,
  output logic [15:0] frame_count,
  output logic        err_line_len,
  output logic        err_frame_lines,
  output logic        err_overflow,
  input  logic        clear_err
);

  state_e      state_q, state_d;
  logic        frame_active_q, frame_active_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [9:0]  line_cnt_q, line_cnt_d;
  logic [11:0] pix_cnt_q, pix_cnt_d;
  logic        sof_pend_q, sof_pend_d;
  logic        held_valid_q, held_valid_d;
  logic [9:0]  held_px_q, held_px_d;
  logic        err_line_len_q, err_line_len_d;
  logic        err_frame_lines_q, err_frame_lines_d;
  logic        err_overflow_q, err_overflow_d;

  logic        push_s;
  logic [11:0] push_data_s;
  logic        set_line_len_s;
  logic        set_frame_lines_s;
  logic        pop_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic [11:0] fifo_head_s;

  mt9v034_sync_fifo #(
    .WIDTH (12),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .pop_data  (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign pop_s         = m_axis_tvalid && m_axis_tready;
  assign m_axis_tvalid = !fifo_empty_s;
  // Mask the head so stale storage never shows on the bus after reset.
  assign m_axis_tdata  = m_axis_tvalid ? {6'd0, fifo_head_s[9:0]} : 16'd0;
  assign m_axis_tuser  = m_axis_tvalid && fifo_head_s[11];
  assign m_axis_tlast  = m_axis_tvalid && fifo_head_s[10];

  assign frame_active    = frame_active_q;
  assign frame_count     = frame_count_q;
  assign err_line_len    = err_line_len_q;
  assign err_frame_lines = err_frame_lines_q;
  assign err_overflow    = err_overflow_q;

  // Decoder FSM next-state, lookahead register, counters and FIFO push.
  always_comb begin
    state_d           = state_q;
    frame_active_d    = frame_active_q;
    frame_count_d     = frame_count_q;
    line_cnt_d        = line_cnt_q;
    pix_cnt_d         = pix_cnt_q;
    sof_pend_d        = sof_pend_q;
    held_valid_d      = held_valid_q;
    held_px_d         = held_px_q;
    push_s            = 1'b0;
    push_data_s       = 12'd0;
    set_line_len_s    = 1'b0;
    set_frame_lines_s = 1'b0;

    if (in_valid) begin
      case (state_q)
        IDLE: begin
          if (in_data == SYNC_FS0) begin
            state_d = SYNC1;
          end else begin
            state_d = IDLE;
          end
        end
        SYNC1: begin
          if (in_data == SYNC_FS1) begin
            state_d = SYNC2;
          end else if (in_data == SYNC_FS0) begin
            state_d = SYNC1;
          end else begin
            state_d = IDLE;
          end
        end
        SYNC2: begin
          if (in_data == SYNC_FS0) begin
            state_d        = FRAME;
            frame_active_d = 1'b1;
            line_cnt_d     = 10'd0;
            sof_pend_d     = 1'b1;
            held_valid_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        FRAME: begin
          if (in_data == SYNC_LS) begin
            state_d      = LINE;
            pix_cnt_d    = 12'd0;
            held_valid_d = 1'b0;
          end else if (in_data == SYNC_FE) begin
            state_d           = IDLE;
            frame_active_d    = 1'b0;
            frame_count_d     = frame_count_q + 16'd1;
            set_frame_lines_s = (line_cnt_q != 10'(V_ACTIVE));
          end else if (in_data == SYNC_FS0) begin
            // New frame-start before frame-end: abandon the current frame.
            state_d           = SYNC1;
            frame_active_d    = 1'b0;
            set_frame_lines_s = 1'b1;
          end else begin
            state_d = FRAME;
          end
        end
        LINE: begin
          if (in_data == SYNC_LE) begin
            state_d        = FRAME;
            line_cnt_d     = line_sat_inc(line_cnt_q);
            set_line_len_s = (pix_cnt_q != 12'(H_ACTIVE));
            held_valid_d   = 1'b0;
            if (held_valid_q) begin
              push_s      = 1'b1;
              push_data_s = {sof_pend_q, 1'b1, held_px_q};
              sof_pend_d  = 1'b0;
            end else begin
              push_s = 1'b0;
            end
          end else begin
            // Any non-end word inside a line is a pixel; release the held one.
            state_d      = LINE;
            held_px_d    = in_data;
            held_valid_d = 1'b1;
            pix_cnt_d    = pix_sat_inc(pix_cnt_q);
            if (held_valid_q) begin
              push_s      = 1'b1;
              push_data_s = {sof_pend_q, 1'b0, held_px_q};
              sof_pend_d  = 1'b0;
            end else begin
              push_s = 1'b0;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Sticky error next-state; a new error wins over a same-cycle clear.
  always_comb begin
    err_line_len_d    = (err_line_len_q    && !clear_err) || set_line_len_s;
    err_frame_lines_d = (err_frame_lines_q && !clear_err) || set_frame_lines_s;
    err_overflow_d    = (err_overflow_q    && !clear_err) ||
                        (push_s && fifo_full_s && !pop_s);
  end

  // State, counter and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      frame_active_q    <= 1'b0;
      frame_count_q     <= 16'd0;
      line_cnt_q        <= 10'd0;
      pix_cnt_q         <= 12'd0;
      sof_pend_q        <= 1'b0;
      held_valid_q      <= 1'b0;
      held_px_q         <= 10'd0;
      err_line_len_q    <= 1'b0;
      err_frame_lines_q <= 1'b0;
      err_overflow_q    <= 1'b0;
    end else begin
      state_q           <= state_d;
      frame_active_q    <= frame_active_d;
      frame_count_q     <= frame_count_d;
      line_cnt_q        <= line_cnt_d;
      pix_cnt_q         <= pix_cnt_d;
      sof_pend_q        <= sof_pend_d;
      held_valid_q      <= held_valid_d;
      held_px_q         <= held_px_d;
      err_line_len_q    <= err_line_len_d;
      err_frame_lines_q <= err_frame_lines_d;
      err_overflow_q    <= err_overflow_d;
    end
  end

endmodule
